logic_unit_seq: RTL and testbench

- Parametrised, registered successor to the team's two-input gate block: one WIDTH-bit bitwise logic unit with an opcode select in place of seven fixed gate outputs.
- Adds valid/ready handshaking, a one-deep output register, result flags, a transfer counter, and an accumulate mode that folds a burst of operands into one result.
- Sits between a stream producer and consumer as a pipelined logic stage.

---
 rtl/logic_unit_pkg.sv | 20 ++
 rtl/logic_unit_seq_if.sv | 30 +++
 rtl/logic_op_core.sv | 28 ++
 rtl/logic_unit_seq.sv | 110 +++++++++++
 tb/tb_logic_unit_seq.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/logic_unit_pkg.sv
// Shared types for the registered logic unit: opcode and FSM state encodings.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_XOR  = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

endpackage

// File: rtl/logic_unit_seq_if.sv
// Stream handshake bundle between producer, logic unit and consumer.
interface logic_unit_seq_if #(
    parameter int WIDTH = 8
);
    import logic_unit_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    op_e              in_op;
    logic             in_acc;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic             out_parity;

    modport master (
        output in_valid, in_a, in_b, in_op, in_acc, in_last, out_ready,
        input  in_ready, out_valid, out_y, out_zero, out_parity
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_acc, in_last, out_ready,
        output in_ready, out_valid, out_y, out_zero, out_parity
    );

endinterface

// File: rtl/logic_op_core.sv
// Combinational WIDTH-bit bitwise operator selected by opcode.
module logic_op_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_out
);

    always_comb begin
        y_out = x;
        case (op)
            OP_AND:  y_out = x & y;
            OP_OR:   y_out = x | y;
            OP_NAND: y_out = ~(x & y);
            OP_XOR:  y_out = x ^ y;
            OP_NOR:  y_out = ~(x | y);
            OP_XNOR: y_out = ~(x ^ y);
            OP_NOT:  y_out = ~x;
            OP_PASS: y_out = x;
            default: y_out = x;
        endcase
    end

endmodule

// File: rtl/logic_unit_seq.sv
// Pipelined logic stage: one-deep output register, result flags, transfer
// counter and an optional accumulate mode folding a burst into one result.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | single ops go straight to the output; in_acc starts a burst
//   ST_ACC  | burst in progress; x operand is acc, in_last emits result
module logic_unit_seq
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ACC_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    logic_unit_seq_if.slave   bus,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0] out_y_q;
    logic             out_valid_q, out_zero_q, out_parity_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] x_sel, f;
    logic             accept, xfer, load;

    assign bus.in_ready   = !out_valid_q || bus.out_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_y      = out_y_q;
    assign bus.out_zero   = out_zero_q;
    assign bus.out_parity = out_parity_q;
    assign op_count       = cnt_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign xfer   = out_valid_q && bus.out_ready;
    assign x_sel  = (state == ST_ACC) ? acc : bus.in_a;

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .op    (bus.in_op),
        .x     (x_sel),
        .y     (bus.in_b),
        .y_out (f)
    );

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        load      = 1'b0;
        if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_acc && (ACC_EN != 0)) begin
                        acc_nxt = f;
                        if (bus.in_last) load = 1'b1;
                        else             state_nxt = ST_ACC;
                    end else begin
                        load = 1'b1;
                    end
                end
                ST_ACC: begin
                    if (bus.in_last) begin
                        load      = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        acc_nxt = f;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
        end
    end

    // Load wins over drain so a same-cycle transfer and new beat keep valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_y_q      <= '0;
            out_zero_q   <= 1'b1;
            out_parity_q <= 1'b0;
        end else if (load) begin
            out_valid_q  <= 1'b1;
            out_y_q      <= f;
            out_zero_q   <= (f == '0);
            out_parity_q <= ^f;
        end else if (xfer) begin
            out_valid_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       cnt_q <= '0;
        else if (xfer && cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_ONE;
    end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed bench for logic_unit_seq: ops, flags, backpressure, bursts, reset, saturation.
module tb_logic_unit_seq;
    import logic_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    logic_unit_seq_if #(.WIDTH(8)) bus  ();
    logic_unit_seq_if #(.WIDTH(8)) bus4 ();

    logic_unit_seq #(.WIDTH(8), .ACC_EN(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .op_count(cnt));

    logic_unit_seq #(.WIDTH(8), .ACC_EN(1), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .op_count(cnt4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic acc, input logic last);
        bus.in_valid = v;
        bus.in_op    = op_e'(op);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_acc   = acc;
        bus.in_last  = last;
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd0, 8'hC3, 8'hA5, 1'b0, 1'b0);
        tick();
        tests++;
        if (bus.out_valid !== 1'b1) begin
            fails++; $display("FAIL pre_reset_valid got %b want 1", bus.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_zero !== 1'b1 ||
            bus.out_parity !== 1'b0 || bus.out_y !== 8'h00 || cnt !== 16'd0) begin
            fails++;
            $display("FAIL async_reset got v=%b rdy=%b z=%b p=%b y=%h cnt=%0d want 0 1 1 0 00 0",
                     bus.out_valid, bus.in_ready, bus.out_zero, bus.out_parity, bus.out_y, cnt);
        end
        repeat (3) @(posedge clk);
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_hold_valid got %b want 0", bus.out_valid);
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_ops();
        logic [7:0] exp [8] = '{8'h81, 8'hE7, 8'h7E, 8'h66, 8'h18, 8'h99, 8'h3C, 8'hC3};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 8'hC3, 8'hA5, 1'b0, 1'b0);
            tick();
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_y !== exp[i] ||
                bus.out_zero !== 1'b0 || bus.out_parity !== ^exp[i]) begin
                fails++;
                $display("FAIL single_op%0d got v=%b y=%h z=%b p=%b want 1 %h 0 %b",
                         i, bus.out_valid, bus.out_y, bus.out_zero, bus.out_parity, exp[i], ^exp[i]);
            end
            if (i == 3) begin
                tests++;
                if (bus.out_zero !== 1'b0 || bus.out_parity !== 1'b0) begin
                    fails++;
                    $display("FAIL xor_flags got z=%b p=%b want 0 0", bus.out_zero, bus.out_parity);
                end
            end
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        tests++;
        if (bus.out_valid !== 1'b0 || cnt !== 16'd8) begin
            fails++; $display("FAIL single_count got v=%b cnt=%0d want 0 8", bus.out_valid, cnt);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd1, 8'h0F, 8'hF0, 1'b0, 1'b0);
        tick();
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_y !== 8'hFF) begin
            fails++; $display("FAIL bp_first got v=%b y=%h want 1 ff", bus.out_valid, bus.out_y);
        end
        drive(1'b1, 3'd0, 8'hFF, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (bus.in_ready !== 1'b0 || bus.out_y !== 8'hFF || bus.out_valid !== 1'b1 ||
                bus.out_parity !== 1'b0 || bus.out_zero !== 1'b0 || cnt !== 16'd8) begin
                fails++;
                $display("FAIL bp_hold%0d got rdy=%b y=%h v=%b cnt=%0d want 0 ff 1 8",
                         i, bus.in_ready, bus.out_y, bus.out_valid, cnt);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_ready_follow got %b want 1", bus.in_ready);
        end
        tick();
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_y !== 8'h3C || cnt !== 16'd9) begin
            fails++;
            $display("FAIL bp_drain_load got v=%b y=%h cnt=%0d want 1 3c 9", bus.out_valid, bus.out_y, cnt);
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        tests++;
        if (bus.out_valid !== 1'b0 || cnt !== 16'd10) begin
            fails++; $display("FAIL bp_final got v=%b cnt=%0d want 0 10", bus.out_valid, cnt);
        end
    endtask

    task automatic test_accumulate();
        logic [7:0] last_b [2] = '{8'h30, 8'h00};
        logic [7:0] exp_y  [2] = '{8'h30, 8'h00};
        logic       exp_z  [2] = '{1'b0, 1'b1};
        bus.out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, 3'd3, 8'h0F, 8'hF0, 1'b1, 1'b0);
            tick();
            tests++;
            if (bus.out_valid !== 1'b0) begin
                fails++; $display("FAIL acc%0d_beat1 got v=%b want 0", r, bus.out_valid);
            end
            drive(1'b1, 3'd3, 8'hAA, 8'h0F, 1'b0, 1'b0);
            tick();
            tests++;
            if (bus.out_valid !== 1'b0) begin
                fails++; $display("FAIL acc%0d_beat2 got v=%b want 0", r, bus.out_valid);
            end
            drive(1'b1, 3'd0, 8'h55, last_b[r], 1'b1, 1'b1);
            tick();
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_y !== exp_y[r] ||
                bus.out_zero !== exp_z[r] || bus.out_parity !== 1'b0) begin
                fails++;
                $display("FAIL acc%0d_result got v=%b y=%h z=%b p=%b want 1 %h %b 0",
                         r, bus.out_valid, bus.out_y, bus.out_zero, bus.out_parity, exp_y[r], exp_z[r]);
            end
            drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
            tick();
            tests++;
            if (bus.out_valid !== 1'b0) begin
                fails++; $display("FAIL acc%0d_single got v=%b want 0", r, bus.out_valid);
            end
        end
        tests++;
        if (cnt !== 16'd12) begin
            fails++; $display("FAIL acc_count got %0d want 12", cnt);
        end
    endtask

    task automatic test_reset_mid_burst();
        bus.out_ready = 1'b1;
        drive(1'b1, 3'd3, 8'h0F, 8'hF0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 3'd3, 8'h00, 8'h0F, 1'b0, 1'b0);
        tick();
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (bus.out_valid !== 1'b0 || cnt !== 16'd0) begin
            fails++; $display("FAIL midburst_discard got v=%b cnt=%0d want 0 0", bus.out_valid, cnt);
        end
        drive(1'b1, 3'd1, 8'h01, 8'h02, 1'b0, 1'b0);
        tick();
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_y !== 8'h03) begin
            fails++; $display("FAIL midburst_next got v=%b y=%h want 1 03", bus.out_valid, bus.out_y);
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_saturation();
        int exp;
        bus4.out_ready = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            bus4.in_valid = (k <= 20);
            bus4.in_op    = OP_PASS;
            bus4.in_a     = 8'(k);
            tick();
            exp = (k - 1 > 15) ? 15 : k - 1;
            if (k == 22) exp = 15;
            tests++;
            if (cnt4 !== 4'(exp)) begin
                fails++; $display("FAIL sat_count edge%0d got %0d want %0d", k, cnt4, exp);
            end
        end
        bus4.in_valid = 1'b0;
    endtask

    initial begin
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        bus.out_ready  = 1'b0;
        bus4.in_valid  = 1'b0;
        bus4.in_a      = 8'h00;
        bus4.in_b      = 8'h00;
        bus4.in_op     = OP_AND;
        bus4.in_acc    = 1'b0;
        bus4.in_last   = 1'b0;
        bus4.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        test_reset();
        test_single_ops();
        test_backpressure();
        test_accumulate();
        test_reset_mid_burst();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
